// File: rtl/median_window_gen.sv
// Builds 3x4 pixel windows for a median filter from a stream of two-column beats.
// Each window joins the held column pair with the newly accepted pair.
module median_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int COL_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sol,
    input  logic                  in_eol,
    input  logic [DATA_WIDTH-1:0] in_a_ym1,
    input  logic [DATA_WIDTH-1:0] in_a_y0,
    input  logic [DATA_WIDTH-1:0] in_a_y1,
    input  logic [DATA_WIDTH-1:0] in_b_ym1,
    input  logic [DATA_WIDTH-1:0] in_b_y0,
    input  logic [DATA_WIDTH-1:0] in_b_y1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] xm1_y1,
    output logic [DATA_WIDTH-1:0] xm1_y0,
    output logic [DATA_WIDTH-1:0] xm1_ym1,
    output logic [DATA_WIDTH-1:0] x0_y1,
    output logic [DATA_WIDTH-1:0] x0_y0,
    output logic [DATA_WIDTH-1:0] x0_ym1,
    output logic [DATA_WIDTH-1:0] x1_y1,
    output logic [DATA_WIDTH-1:0] x1_y0,
    output logic [DATA_WIDTH-1:0] x1_ym1,
    output logic [DATA_WIDTH-1:0] x2_y1,
    output logic [DATA_WIDTH-1:0] x2_y0,
    output logic [DATA_WIDTH-1:0] x2_ym1,
    output logic                  out_eol,
    output logic [COL_WIDTH-1:0]  out_col,
    output logic                  err
);

    localparam logic [1:0] EMPTY  = 2'd0;
    localparam logic [1:0] PRIMED = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;

    logic [1:0]            state;
    logic [COL_WIDTH-1:0]  col_cnt;
    logic [DATA_WIDTH-1:0] held_a_ym1_p0, held_a_y0_p0, held_a_y1_p0;
    logic [DATA_WIDTH-1:0] held_b_ym1_p0, held_b_y0_p0, held_b_y1_p0;
    logic                  accept;
    logic                  emit;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // A window is produced only by a continuation beat of an open line.
    assign emit     = accept && !in_sol && (state != EMPTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            col_cnt   <= '0;
            out_valid <= 1'b0;
            out_eol   <= 1'b0;
            out_col   <= '0;
            err       <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (in_sol) begin
                    // A restart while a line is open abandons that line.
                    if (state != EMPTY) begin
                        err <= 1'b1;
                    end
                    col_cnt <= '0;
                    state   <= in_eol ? EMPTY : PRIMED;
                end else if (state == EMPTY) begin
                    err <= 1'b1;
                end else begin
                    out_valid <= 1'b1;
                    out_eol   <= in_eol;
                    out_col   <= col_cnt;
                    col_cnt   <= col_cnt + COL_WIDTH'(1);
                    state     <= in_eol ? EMPTY : STREAM;
                end
            end
        end
    end

    // Held pair: the most recent accepted beat of the open line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_a_ym1_p0 <= '0;
            held_a_y0_p0  <= '0;
            held_a_y1_p0  <= '0;
            held_b_ym1_p0 <= '0;
            held_b_y0_p0  <= '0;
            held_b_y1_p0  <= '0;
        end else if (accept && (in_sol || state != EMPTY)) begin
            held_a_ym1_p0 <= in_a_ym1;
            held_a_y0_p0  <= in_a_y0;
            held_a_y1_p0  <= in_a_y1;
            held_b_ym1_p0 <= in_b_ym1;
            held_b_y0_p0  <= in_b_y0;
            held_b_y1_p0  <= in_b_y1;
        end
    end

    // Window register: loaded only on emit, so it holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xm1_y1  <= '0;
            xm1_y0  <= '0;
            xm1_ym1 <= '0;
            x0_y1   <= '0;
            x0_y0   <= '0;
            x0_ym1  <= '0;
            x1_y1   <= '0;
            x1_y0   <= '0;
            x1_ym1  <= '0;
            x2_y1   <= '0;
            x2_y0   <= '0;
            x2_ym1  <= '0;
        end else if (emit) begin
            xm1_y1  <= held_a_y1_p0;
            xm1_y0  <= held_a_y0_p0;
            xm1_ym1 <= held_a_ym1_p0;
            x0_y1   <= held_b_y1_p0;
            x0_y0   <= held_b_y0_p0;
            x0_ym1  <= held_b_ym1_p0;
            x1_y1   <= in_a_y1;
            x1_y0   <= in_a_y0;
            x1_ym1  <= in_a_ym1;
            x2_y1   <= in_b_y1;
            x2_y0   <= in_b_y0;
            x2_ym1  <= in_b_ym1;
        end
    end

endmodule

// File: tb/tb_median_window_gen.sv
// Bench for median_window_gen: directed scenarios plus random lines checked
// against a line-buffer model (window k = beat k-1 joined with beat k).
module tb_median_window_gen;

    localparam int DW = 8;
    localparam int CW = 4;
    localparam int PW = 6 * DW;
    localparam int WW = 12 * DW + 1 + CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_ready, in_sol = 1'b0, in_eol = 1'b0;
    logic [DW-1:0] in_a_ym1 = '0, in_a_y0 = '0, in_a_y1 = '0;
    logic [DW-1:0] in_b_ym1 = '0, in_b_y0 = '0, in_b_y1 = '0;
    logic          out_valid, out_ready = 1'b0, out_eol, err;
    logic [DW-1:0] xm1_y1, xm1_y0, xm1_ym1, x0_y1, x0_y0, x0_ym1;
    logic [DW-1:0] x1_y1, x1_y0, x1_ym1, x2_y1, x2_y0, x2_ym1;
    logic [CW-1:0] out_col;

    median_window_gen #(.DATA_WIDTH(DW), .COL_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sol(in_sol), .in_eol(in_eol),
        .in_a_ym1(in_a_ym1), .in_a_y0(in_a_y0), .in_a_y1(in_a_y1),
        .in_b_ym1(in_b_ym1), .in_b_y0(in_b_y0), .in_b_y1(in_b_y1),
        .out_valid(out_valid), .out_ready(out_ready),
        .xm1_y1(xm1_y1), .xm1_y0(xm1_y0), .xm1_ym1(xm1_ym1),
        .x0_y1(x0_y1), .x0_y0(x0_y0), .x0_ym1(x0_ym1),
        .x1_y1(x1_y1), .x1_y0(x1_y0), .x1_ym1(x1_ym1),
        .x2_y1(x2_y1), .x2_y0(x2_y0), .x2_ym1(x2_ym1),
        .out_eol(out_eol), .out_col(out_col), .err(err)
    );

    always #5 clk = ~clk;

    int              checks = 0;
    int              failures = 0;
    logic [PW-1:0]   line_q[$];
    logic [WW-1:0]   exp_q[$];
    logic            exp_err = 1'b0;

    logic            hs, acc, eok;
    logic [WW-1:0]   got, exp, held;

    function automatic logic [PW-1:0] mk(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return {a, a, a, b, b, b};
    endfunction

    function automatic logic [PW-1:0] rnd_pair();
        return PW'({$urandom(), $urandom()});
    endfunction

    task automatic model_reset();
        line_q.delete();
        exp_q.delete();
        exp_err = 1'b0;
    endtask

    task automatic model_accept(input logic sol, input logic eol, input logic [PW-1:0] pair);
        logic [CW-1:0] col;
        if (sol) begin
            if (line_q.size() != 0) exp_err = 1'b1;
            line_q.delete();
            if (!eol) line_q.push_back(pair);
        end else if (line_q.size() == 0) begin
            exp_err = 1'b1;
        end else begin
            col = CW'(line_q.size() - 1);
            exp_q.push_back({line_q[line_q.size()-1], pair, eol, col});
            if (eol) line_q.delete();
            else line_q.push_back(pair);
        end
    endtask

    task automatic cycle(input logic v, input logic sol, input logic eol, input logic [PW-1:0] pair,
                         input logic rdy, output logic o_hs, output logic o_acc,
                         output logic [WW-1:0] o_got, output logic o_eok, output logic [WW-1:0] o_exp);
        @(posedge clk);
        #1;
        in_valid = v; in_sol = sol; in_eol = eol; out_ready = rdy;
        {in_a_ym1, in_a_y0, in_a_y1, in_b_ym1, in_b_y0, in_b_y1} = pair;
        @(negedge clk);
        o_hs  = out_valid && out_ready;
        o_acc = in_valid && in_ready;
        o_got = {xm1_ym1, xm1_y0, xm1_y1, x0_ym1, x0_y0, x0_y1,
                 x1_ym1, x1_y0, x1_y1, x2_ym1, x2_y0, x2_y1, out_eol, out_col};
        o_eok = 1'b0;
        o_exp = '0;
        if (o_hs && exp_q.size() > 0) begin
            o_eok = 1'b1;
            o_exp = exp_q.pop_front();
        end
        if (o_acc) model_accept(sol, eol, pair);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_sol = 1'b0; in_eol = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got v=%b rdy=%b err=%b want v=0 rdy=1 err=0", out_valid, in_ready, err);
        end
        got = {xm1_ym1, xm1_y0, xm1_y1, x0_ym1, x0_y0, x0_y1,
               x1_ym1, x1_y0, x1_y1, x2_ym1, x2_y0, x2_y1, out_eol, out_col};
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL reset_window got=%h want=0", got);
        end
        do_reset();
    endtask

    task automatic test_line3();
        do_reset();
        cycle(1, 1, 0, mk(1, 2), 1, hs, acc, got, eok, exp);
        checks++;
        if (hs !== 1'b0 || acc !== 1'b1) begin
            failures++;
            $display("FAIL line3_beat1 got hs=%b acc=%b want hs=0 acc=1", hs, acc);
        end
        cycle(1, 0, 0, mk(3, 4), 1, hs, acc, got, eok, exp);
        checks++;
        if (hs !== 1'b0) begin
            failures++;
            $display("FAIL line3_beat2 got out_valid=%b want 0", hs);
        end
        cycle(1, 0, 1, mk(5, 6), 1, hs, acc, got, eok, exp);
        checks++;
        if (hs !== 1'b1 || got !== {mk(1, 2), mk(3, 4), 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL line3_win0 got v=%b w=%h want v=1 w=%h", hs, got, {mk(1, 2), mk(3, 4), 1'b0, 4'd0});
        end
        cycle(0, 0, 0, '0, 1, hs, acc, got, eok, exp);
        checks++;
        if (hs !== 1'b1 || got !== {mk(3, 4), mk(5, 6), 1'b1, 4'd1}) begin
            failures++;
            $display("FAIL line3_win1 got v=%b w=%h want v=1 w=%h", hs, got, {mk(3, 4), mk(5, 6), 1'b1, 4'd1});
        end
        cycle(0, 0, 0, '0, 1, hs, acc, got, eok, exp);
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL line3_idle got v=%b err=%b want v=0 err=0", out_valid, err);
        end
        // Line is closed: a continuation beat must now be flagged.
        cycle(1, 0, 0, mk(7, 8), 1, hs, acc, got, eok, exp);
        cycle(0, 0, 0, '0, 1, hs, acc, got, eok, exp);
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL line3_closed got v=%b err=%b want v=0 err=1", out_valid, err);
        end
    endtask

    task automatic test_bad_start();
        do_reset();
        cycle(1, 0, 0, rnd_pair(), 1, hs, acc, got, eok, exp);
        cycle(0, 0, 0, '0, 1, hs, acc, got, eok, exp);
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL bad_start got v=%b err=%b want v=0 err=1", out_valid, err);
        end
        for (int k = 0; k < 6; k++) begin
            cycle(k < 4, k == 0, k == 3, rnd_pair(), 1, hs, acc, got, eok, exp);
            if (hs) begin
                checks++;
                if (!eok || got !== exp) begin
                    failures++;
                    $display("FAIL bad_start_line got=%h want=%h known=%b", got, exp, eok);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || err !== 1'b1) begin
            failures++;
            $display("FAIL bad_start_tail got pending=%0d err=%b want pending=0 err=1", exp_q.size(), err);
        end
    endtask

    task automatic test_mid_sol();
        logic [PW-1:0] p3, p4;
        do_reset();
        p3 = rnd_pair();
        p4 = rnd_pair();
        for (int k = 0; k < 6; k++) begin
            cycle(k < 4, k == 0 || k == 2, k == 3, (k == 2) ? p3 : (k == 3) ? p4 : rnd_pair(), 1,
                  hs, acc, got, eok, exp);
            if (hs) begin
                checks++;
                if (!eok || got !== exp) begin
                    failures++;
                    $display("FAIL mid_sol_window got=%h want=%h known=%b", got, exp, eok);
                end
                if (k == 4) begin
                    checks++;
                    if (got !== {p3, p4, 1'b1, 4'd0}) begin
                        failures++;
                        $display("FAIL mid_sol_restart got=%h want=%h", got, {p3, p4, 1'b1, 4'd0});
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || err !== 1'b1) begin
            failures++;
            $display("FAIL mid_sol_tail got pending=%0d err=%b want pending=0 err=1", exp_q.size(), err);
        end
    endtask

    task automatic test_single();
        do_reset();
        cycle(1, 1, 1, rnd_pair(), 1, hs, acc, got, eok, exp);
        cycle(0, 0, 0, '0, 1, hs, acc, got, eok, exp);
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL single_beat got v=%b err=%b want v=0 err=0", out_valid, err);
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] p3;
        int tries;
        do_reset();
        p3 = rnd_pair();
        cycle(1, 1, 0, rnd_pair(), 1, hs, acc, got, eok, exp);
        cycle(1, 0, 0, rnd_pair(), 0, hs, acc, got, eok, exp);
        for (int k = 0; k < 5; k++) begin
            cycle(1, 0, 0, p3, 0, hs, acc, got, eok, exp);
            if (k == 0) held = got;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc !== 1'b0 || got !== held) begin
                failures++;
                $display("FAIL bp_stall got v=%b rdy=%b w=%h want v=1 rdy=0 w=%h", out_valid, in_ready, got, held);
            end
        end
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 20) begin
            cycle(1, 0, 0, p3, 1, hs, acc, got, eok, exp);
            tries++;
            if (hs) begin
                checks++;
                if (!eok || got !== exp) begin
                    failures++;
                    $display("FAIL bp_release got=%h want=%h known=%b", got, exp, eok);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            cycle(k == 0, 1'b0, k == 0, rnd_pair(), 1, hs, acc, got, eok, exp);
            if (hs) begin
                checks++;
                if (!eok || got !== exp) begin
                    failures++;
                    $display("FAIL bp_drain got=%h want=%h known=%b", got, exp, eok);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || tries >= 20) begin
            failures++;
            $display("FAIL bp_lost got pending=%0d tries=%0d want pending=0", exp_q.size(), tries);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1, 1, 0, rnd_pair(), 1, hs, acc, got, eok, exp);
        cycle(1, 0, 0, rnd_pair(), 0, hs, acc, got, eok, exp);
        cycle(0, 0, 0, '0, 0, hs, acc, got, eok, exp);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre got v=%b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_col !== '0) begin
            failures++;
            $display("FAIL areset_drop got v=%b rdy=%b col=%0d want v=0 rdy=1 col=0", out_valid, in_ready, out_col);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            cycle(k < 4, k == 0, k == 3, rnd_pair(), 1, hs, acc, got, eok, exp);
            if (hs) begin
                checks++;
                if (!eok || got !== exp || (k == 2 && got[CW-1:0] !== '0)) begin
                    failures++;
                    $display("FAIL areset_line got=%h want=%h known=%b", got, exp, eok);
                end
            end
        end
    endtask

    task automatic test_random();
        int len, tries;
        logic [PW-1:0] p;
        do_reset();
        for (int l = 0; l < 8; l++) begin
            len = (l == 0) ? 20 : $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin
                p = rnd_pair();
                acc = 1'b0;
                tries = 0;
                while (!acc && tries < 200) begin
                    cycle($urandom_range(0, 3) != 0, k == 0, k == len - 1, p, $urandom_range(0, 2) != 0,
                          hs, acc, got, eok, exp);
                    tries++;
                    if (hs) begin
                        checks++;
                        if (!eok || got !== exp) begin
                            failures++;
                            $display("FAIL random_window got=%h want=%h known=%b", got, exp, eok);
                        end
                    end
                end
                if (tries >= 200) begin
                    checks++;
                    failures++;
                    $display("FAIL random_stuck got no accept want accept within 200 cycles");
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, '0, 1, hs, acc, got, eok, exp);
            if (hs) begin
                checks++;
                if (!eok || got !== exp) begin
                    failures++;
                    $display("FAIL random_drain got=%h want=%h known=%b", got, exp, eok);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || err !== exp_err) begin
            failures++;
            $display("FAIL random_tail got pending=%0d err=%b want pending=0 err=%b", exp_q.size(), err, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_line3();
        test_bad_start();
        test_mid_sol();
        test_single();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
